// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Run/step/halt sequencer for the SIMPLE CPU. Generates the one-hot
//   phase1..phase6 strobes, turns the raw exec push-button into run, pause and
//   single-step control, stops permanently on a halt request and counts
//   retired instructions for the debug display.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high; clears all state
//   exec        raw exec push-button (asynchronous to clk)
//   step_mode   1 = one instruction per exec press, 0 = free run
//   halt_req    halt instruction decoded by the controller
//   stall       hold the current phase for this cycle
//   phase1..6   one-hot phase strobes (all zero outside RUN)
//   running     sequencer is in RUN
//   halted      sequencer is in HALT
//   inst_count  instructions retired since reset (wraps)
module phase_sequencer #(
    parameter int DB_CYCLES = 16,
    parameter int DBW       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exec,
    input  logic        step_mode,
    input  logic        halt_req,
    input  logic        stall,
    output logic        phase1,
    output logic        phase2,
    output logic        phase3,
    output logic        phase4,
    output logic        phase5,
    output logic        phase6,
    output logic        running,
    output logic        halted,
    output logic [15:0] inst_count
);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     phase_q, phase_d;
    logic [15:0]    inst_count_q, inst_count_d;
    logic           halt_pend_q, halt_pend_d;
    logic           pause_pend_q, pause_pend_d;

    logic           sync1_q, sync2_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           exec_db_q, exec_db_d;
    logic           exec_db_prev_q;
    logic           exec_press_q, exec_press_d;

    logic           halt_now;
    logic           pause_now;

    // Debounce: the level only moves after DB_CYCLES consecutive cycles of
    // disagreement; any agreeing cycle restarts the count.
    always_comb begin
        exec_db_d    = exec_db_q;
        db_cnt_d     = '0;
        if (sync2_q != exec_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                exec_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        // Registered rising-edge pulse of the debounced level.
        exec_press_d = exec_db_q & ~exec_db_prev_q;
    end

    // Requests arriving in the completing cycle itself still count for it.
    assign halt_now  = halt_pend_q | halt_req;
    assign pause_now = pause_pend_q | exec_press_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        inst_count_d = inst_count_q;
        halt_pend_d  = halt_pend_q;
        pause_pend_d = pause_pend_q;

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (exec_press_q) begin
                    state_d = S_RUN;
                    phase_d = 6'b000001;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (exec_press_q) begin
                    pause_pend_d = 1'b1;
                end
                if (!stall) begin
                    if (phase_q[5]) begin
                        inst_count_d = inst_count_q + 16'd1;
                        halt_pend_d  = 1'b0;
                        pause_pend_d = 1'b0;
                        // step_mode is only looked at here, at the boundary.
                        if (halt_now) begin
                            state_d = S_HALT;
                            phase_d = '0;
                        end else if (pause_now || step_mode) begin
                            state_d = S_IDLE;
                            phase_d = '0;
                        end else begin
                            phase_d = 6'b000001;
                        end
                    end else begin
                        phase_d = {phase_q[4:0], 1'b0};
                    end
                end
            end
            S_HALT: begin
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            inst_count_q   <= '0;
            halt_pend_q    <= 1'b0;
            pause_pend_q   <= 1'b0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            db_cnt_q       <= '0;
            exec_db_q      <= 1'b0;
            exec_db_prev_q <= 1'b0;
            exec_press_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            inst_count_q   <= inst_count_d;
            halt_pend_q    <= halt_pend_d;
            pause_pend_q   <= pause_pend_d;
            sync1_q        <= exec;
            sync2_q        <= sync1_q;
            db_cnt_q       <= db_cnt_d;
            exec_db_q      <= exec_db_d;
            exec_db_prev_q <= exec_db_q;
            exec_press_q   <= exec_press_d;
        end
    end

    // Outputs come straight from flops so reset clears them without a clock.
    assign phase1     = phase_q[0];
    assign phase2     = phase_q[1];
    assign phase3     = phase_q[2];
    assign phase4     = phase_q[3];
    assign phase5     = phase_q[4];
    assign phase6     = phase_q[5];
    assign running    = (state_q == S_RUN);
    assign halted     = (state_q == S_HALT);
    assign inst_count = inst_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        exec;
    logic        step_mode;
    logic        halt_req;
    logic        stall;
    logic        phase1, phase2, phase3, phase4, phase5, phase6;
    logic        running;
    logic        halted;
    logic [15:0] inst_count;

    phase_sequencer #(.DB_CYCLES(16), .DBW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .exec       (exec),
        .step_mode  (step_mode),
        .halt_req   (halt_req),
        .stall      (stall),
        .phase1     (phase1),
        .phase2     (phase2),
        .phase3     (phase3),
        .phase4     (phase4),
        .phase5     (phase5),
        .phase6     (phase6),
        .running    (running),
        .halted     (halted),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  ph;
        logic        run;
        logic        hlt;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic        st;
        logic        sm;
        int          ph;
        logic [15:0] cnt;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[22];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [5:0] oh(input int k);
        if (k <= 0) return 6'b0;
        return 6'b000001 << (k - 1);
    endfunction

    task automatic check_next(input string tag);
        exp_t       e;
        logic [5:0] ph;
        ph = {phase6, phase5, phase4, phase3, phase2, phase1};
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty at time %0t", tag, $time);
            return;
        end
        e = sb.pop_front();
        if (ph !== e.ph || running !== e.run || halted !== e.hlt || inst_count !== e.cnt) begin
            n_bad++;
            $display("FAIL %s @%0t: got ph=%b run=%b hlt=%b cnt=%h, want ph=%b run=%b hlt=%b cnt=%h",
                     tag, $time, ph, running, halted, inst_count, e.ph, e.run, e.hlt, e.cnt);
        end
    endtask

    // Drive inputs, queue the expected outputs after the next edge, check.
    task automatic step(input logic e, input logic sm, input logic hr, input logic st,
                        input logic [5:0] ph, input logic run, input logic hlt,
                        input logic [15:0] cnt, input string tag);
        exec      = e;
        step_mode = sm;
        halt_req  = hr;
        stall     = st;
        sb.push_back({ph, run, hlt, cnt});
        @(posedge clk);
        #1;
        check_next(tag);
    endtask

    // Clean exec rise: sampled at edge 0, press after edge 18, phase1 after edge 19.
    task automatic press_start(input logic sm, input logic [15:0] cnt, input string tag);
        for (int i = 0; i < 19; i++) begin
            step(1'b1, sm, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, cnt, tag);
        end
        step(1'b1, sm, 1'b0, 1'b0, oh(1), 1'b1, 1'b0, cnt, tag);
    endtask

    task automatic idle_steps(input int n, input logic sm, input logic [15:0] cnt, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, sm, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, cnt, tag);
        end
    endtask

    initial begin
        // stall / step_mode sequence applied after a free-run start
        tbl = '{
            '{1'b0, 1'b0, 2, 16'd0}, '{1'b0, 1'b0, 3, 16'd0}, '{1'b0, 1'b0, 4, 16'd0},
            '{1'b0, 1'b0, 5, 16'd0}, '{1'b0, 1'b0, 6, 16'd0},
            '{1'b1, 1'b0, 6, 16'd0}, '{1'b1, 1'b0, 6, 16'd0}, '{1'b1, 1'b0, 6, 16'd0},
            '{1'b1, 1'b0, 6, 16'd0},
            '{1'b0, 1'b0, 1, 16'd1}, '{1'b1, 1'b0, 1, 16'd1}, '{1'b0, 1'b0, 2, 16'd1},
            '{1'b0, 1'b1, 3, 16'd1}, '{1'b0, 1'b1, 4, 16'd1}, '{1'b0, 1'b0, 5, 16'd1},
            '{1'b0, 1'b0, 6, 16'd1}, '{1'b0, 1'b0, 1, 16'd2},
            '{1'b0, 1'b1, 2, 16'd2}, '{1'b0, 1'b1, 3, 16'd2}, '{1'b0, 1'b1, 4, 16'd2},
            '{1'b0, 1'b1, 5, 16'd2}, '{1'b0, 1'b1, 6, 16'd2}
        };

        exec      = 1'b0;
        step_mode = 1'b0;
        halt_req  = 1'b0;
        stall     = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back({6'b0, 1'b0, 1'b0, 16'h0});
        check_next("reset_state");
        reset = 1'b0;

        // Free run start with exec held high, then continuous cycling.
        press_start(1'b0, 16'd0, "freerun_start");
        for (int r = 1; r <= 19; r++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, oh(r % 6 + 1), 1'b1, 1'b0, 16'(r / 6), "freerun");
        end
        // Halt requested during phase3: instruction still completes.
        step(1'b0, 1'b0, 1'b0, 1'b0, oh(3), 1'b1, 1'b0, 16'd3, "pre_halt");
        step(1'b0, 1'b0, 1'b1, 1'b0, oh(4), 1'b1, 1'b0, 16'd3, "halt_p4");
        step(1'b0, 1'b0, 1'b0, 1'b0, oh(5), 1'b1, 1'b0, 16'd3, "halt_p5");
        step(1'b0, 1'b0, 1'b0, 1'b0, oh(6), 1'b1, 1'b0, 16'd3, "halt_p6");
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b1, 16'd4, "halted");
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b1, 16'd4, "halt_sticky");
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b1, 16'd4, "halt_sticky_low");
        end
        reset = 1'b1;
        #1;
        sb.push_back({6'b0, 1'b0, 1'b0, 16'h0});
        check_next("reset_from_halt");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_steps(3, 1'b0, 16'd0, "idle_after_reset");

        // Table-driven stall and step_mode sampling.
        press_start(1'b0, 16'd0, "stall_start");
        for (int i = 0; i < 22; i++) begin
            step(1'b0, tbl[i].sm, 1'b0, tbl[i].st, oh(tbl[i].ph), 1'b1, 1'b0, tbl[i].cnt, "stall_tbl");
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 16'd3, "step_sampled_idle");
        idle_steps(5, 1'b1, 16'd3, "idle_gap");

        // Single-step: three presses, one instruction each.
        for (int p = 0; p < 3; p++) begin
            press_start(1'b1, 16'(3 + p), "step_start");
            for (int k = 2; k <= 6; k++) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, oh(k), 1'b1, 1'b0, 16'(3 + p), "step_phase");
            end
            step(1'b0, 1'b1, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 16'(4 + p), "step_done");
            idle_steps(14, 1'b1, 16'(4 + p), "step_gap");
        end

        // Pause: press registered during phase3 of the 8th instruction.
        press_start(1'b0, 16'd6, "pause_start");
        for (int r = 1; r <= 47; r++) begin
            step((r >= 25), 1'b0, 1'b0, 1'b0, oh(r % 6 + 1), 1'b1, 1'b0, 16'(6 + r / 6), "pause_run");
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 16'd14, "pause_idle");
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 16'd14, "pause_hold");
        idle_steps(20, 1'b0, 16'd14, "pause_release");

        // Bouncing exec never produces a press.
        for (int i = 0; i < 100; i++) begin
            step(((i % 8) < 5), 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 16'd14, "bounce");
        end
        idle_steps(20, 1'b0, 16'd14, "bounce_after");

        // Counter wrap: preload 0xFFFF, then retire one instruction.
        force dut.inst_count_q = 16'hFFFF;
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 16'hFFFF, "wrap_preload");
        release dut.inst_count_q;
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 16'hFFFF, "wrap_hold");
        press_start(1'b1, 16'hFFFF, "wrap_start");
        for (int k = 2; k <= 6; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, oh(k), 1'b1, 1'b0, 16'hFFFF, "wrap_phase");
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 16'h0000, "wrap_zero");
        idle_steps(14, 1'b0, 16'h0000, "wrap_gap");

        // Asynchronous reset in phase4 clears outputs before any edge.
        press_start(1'b0, 16'h0000, "areset_start");
        step(1'b0, 1'b0, 1'b0, 1'b0, oh(2), 1'b1, 1'b0, 16'h0000, "areset_p2");
        step(1'b0, 1'b0, 1'b0, 1'b0, oh(3), 1'b1, 1'b0, 16'h0000, "areset_p3");
        step(1'b0, 1'b0, 1'b0, 1'b0, oh(4), 1'b1, 1'b0, 16'h0000, "areset_p4");
        #1;
        reset = 1'b1;
        #1;
        sb.push_back({6'b0, 1'b0, 1'b0, 16'h0});
        check_next("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_steps(4, 1'b0, 16'h0000, "after_async_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
